// File: rtl/mmio_pkg.sv
// Shared register-map constants for the memory-mapped timer peripheral.
package mmio_pkg;

  // Register index (address[3:2]) of each register in the 16-byte window.
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int CTRL_PRESC_LSB = 8;

  // STATUS bit positions.
  localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides the clock by (presc+1) while enabled, producing a
// one-cycle tick each time the counter reaches presc.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  // Tick is decoded from the current count, so presc==0 ticks every enabled cycle.
  assign tick = en && (pcnt == presc);

  // Counter holds 0 while disabled or on a CTRL write, wraps to 0 on tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the CPU memory-access bus.
//
// Bus timing: there is no valid/ready handshake. Every cycle the responder
// samples address; if it falls in the window, wr=1 commits wdata to the
// addressed register at the clock edge, and the read data for that same
// address appears on rdata (with hit=1) one cycle later, holding the
// pre-write value. Out-of-window cycles return rdata=0, hit=0.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  // Register state
  logic                  ctrl_en;
  logic                  ctrl_auto;
  logic                  ctrl_irqen;
  logic [PRESCALE_W-1:0] ctrl_presc;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match;

  // Decode
  logic       sel;
  logic [1:0] idx;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       tick;
  logic       cmp_eq;
  logic       hit_match;
  logic [31:0] ctrl_word;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign sel        = (address[31:4] == BASE_ADDR[31:4]);
  assign idx        = address[3:2];
  assign wr_ctrl    = sel && wr && (idx == OFF_CTRL);
  assign wr_count   = sel && wr && (idx == OFF_COUNT);
  assign wr_compare = sel && wr && (idx == OFF_COMPARE);
  assign wr_status  = sel && wr && (idx == OFF_STATUS);
  assign cmp_eq     = (count == compare);
  assign hit_match  = tick && cmp_eq;
  assign unused_addr_bits = ^address[1:0];

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_en),
    .presc (ctrl_presc),
    .clr   (wr_ctrl),
    .tick  (tick)
  );

  // Assemble the CTRL readback word; reserved bits read as zero.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN]    = ctrl_en;
    ctrl_word[CTRL_AUTO]  = ctrl_auto;
    ctrl_word[CTRL_IRQEN] = ctrl_irqen;
    ctrl_word[CTRL_PRESC_LSB +: PRESCALE_W] = ctrl_presc;
  end

  // Read mux over the four registers, zero outside the window.
  always_comb begin
    rd_mux = '0;
    if (sel) begin
      case (idx)
        OFF_CTRL:    rd_mux = ctrl_word;
        OFF_COUNT:   rd_mux = count;
        OFF_COMPARE: rd_mux = compare;
        OFF_STATUS:  rd_mux[STATUS_MATCH] = match;
        default:     rd_mux = '0;
      endcase
    end
  end

  // Registered read path, matching main-memory one-cycle latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
      hit   <= 1'b0;
    end else begin
      rdata <= rd_mux;
      hit   <= sel;
    end
  end

  // CTRL: CPU write wins over the one-shot enable clear on a non-reload match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_irqen <= 1'b0;
      ctrl_presc <= '0;
    end else if (wr_ctrl) begin
      ctrl_en    <= wdata[CTRL_EN];
      ctrl_auto  <= wdata[CTRL_AUTO];
      ctrl_irqen <= wdata[CTRL_IRQEN];
      ctrl_presc <= wdata[CTRL_PRESC_LSB +: PRESCALE_W];
    end else if (hit_match && !ctrl_auto) begin
      ctrl_en <= 1'b0;
    end
  end

  // COUNT: CPU write wins over the tick update; wraps silently on overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      if (cmp_eq) begin
        if (ctrl_auto) begin
          count <= '0;
        end
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  // COMPARE: plain read/write register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      compare <= '0;
    end else if (wr_compare) begin
      compare <= wdata;
    end
  end

  // STATUS.match: set on a matching tick, which beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset) begin
      match <= 1'b0;
    end else if (hit_match) begin
      match <= 1'b1;
    end else if (wr_status && wdata[STATUS_MATCH]) begin
      match <= 1'b0;
    end
  end

  assign irq = match && ctrl_irqen;

endmodule
